// File: rtl/sc_spi_dbuf_if.sv
// sc_spi_dbuf_if: register-block and SPI-engine signals of the SPI data buffer.
interface sc_spi_dbuf_if;
    logic        txwe;
    logic [31:0] txwdata;
    logic        txclr;
    logic        rxre;
    logic [31:0] rxrdata;
    logic        rxclr;
    logic        go;
    logic [4:0]  txcount;
    logic [4:0]  rxcount;
    logic        txovf;
    logic        rxovf;
    logic        rxerr;
    logic        busy;
    logic        done;
    logic        txstart;
    logic        spibusy;
    logic        spicomplete;
    logic [3:0]  txdpt;
    logic [31:0] txdata;
    logic [31:0] rxdata;
    logic [3:0]  rxdpt;
    logic        rxvalid;
    modport master (
        output txwe, txwdata, txclr, rxre, rxclr, go, spibusy, spicomplete, txdpt, rxdata, rxdpt, rxvalid,
        input  rxrdata, txcount, rxcount, txovf, rxovf, rxerr, busy, done, txstart, txdata
    );
    modport slave (
        input  txwe, txwdata, txclr, rxre, rxclr, go, spibusy, spicomplete, txdpt, rxdata, rxdpt, rxvalid,
        output rxrdata, txcount, rxcount, txovf, rxovf, rxerr, busy, done, txstart, txdata
    );
endinterface

// File: rtl/sc_spi_dbuf.sv
// sc_spi_dbuf: TX word buffer, RX FIFO and transfer sequencer in front of the SPI engine.
module sc_spi_dbuf #(
    parameter int DEPTH = 16,
    parameter int NSYNC = 2
) (
    input logic          sysclk,
    input logic          sysrst,
    sc_spi_dbuf_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, START, RUN, FIN} state_t;
    state_t state, state_nx;
    logic [31:0] txmem [DEPTH];
    logic [31:0] rxmem [DEPTH];
    logic [4:0] txcount, rxcount;
    logic [AW-1:0] wp, rp;
    logic [3:0] exp_idx;
    logic [NSYNC-1:0] sync;
    logic sync_q, spibusy_q, txovf, rxovf, rxerr;
    logic go_ok, tx_full, tx_wr, strobe, cap, pop, rx_full, rx_wr;
    assign go_ok   = state == IDLE && bus.go && txcount != 5'd0 && !bus.spibusy;
    assign tx_full = txcount == 5'(DEPTH);
    assign tx_wr   = bus.txwe && !bus.txclr && state == IDLE && !tx_full;
    assign strobe  = sync[NSYNC-1] && !sync_q;
    assign cap     = strobe && !bus.rxclr;
    assign pop     = bus.rxre && rxcount != 5'd0 && !bus.rxclr;
    assign rx_full = rxcount == 5'(DEPTH);
    // a pop frees the slot in the same cycle, so a full FIFO still accepts the capture
    assign rx_wr   = cap && (!rx_full || pop);
    always_comb begin
        state_nx = state == IDLE  ? (go_ok ? START : IDLE) :
                   state == START ? (bus.spibusy ? RUN : START) :
                   state == RUN   ? ((bus.spicomplete || (spibusy_q && !bus.spibusy)) ? FIN : RUN) :
                   IDLE;
    end
    always_ff @(posedge sysclk or posedge sysrst) begin
        if (sysrst) begin
            state     <= IDLE;
            spibusy_q <= 1'b0;
            txcount   <= '0;
            txovf     <= 1'b0;
        end else begin
            state     <= state_nx;
            spibusy_q <= bus.spibusy;
            txcount   <= (bus.txclr || state == FIN) ? 5'd0 : tx_wr ? txcount + 5'd1 : txcount;
            txovf     <= bus.txclr ? 1'b0 : (bus.txwe && (state != IDLE || tx_full)) ? 1'b1 : txovf;
        end
    end
    always_ff @(posedge sysclk) begin
        if (tx_wr) txmem[txcount[AW-1:0]] <= bus.txwdata;
        if (rx_wr) rxmem[wp] <= bus.rxdata;
    end
    always_ff @(posedge sysclk or posedge sysrst) begin
        if (sysrst) begin
            sync    <= '0;
            sync_q  <= 1'b0;
            exp_idx <= '0;
            wp      <= '0;
            rp      <= '0;
            rxcount <= '0;
            rxovf   <= 1'b0;
            rxerr   <= 1'b0;
        end else begin
            sync    <= {sync[NSYNC-2:0], bus.rxvalid};
            sync_q  <= sync[NSYNC-1];
            exp_idx <= go_ok ? 4'd0 : cap ? exp_idx + 4'd1 : exp_idx;
            if (bus.rxclr) begin
                wp      <= '0;
                rp      <= '0;
                rxcount <= '0;
                rxovf   <= 1'b0;
                rxerr   <= 1'b0;
            end else begin
                if (rx_wr) wp <= wp + 1'b1;
                if (pop) rp <= rp + 1'b1;
                rxcount <= rxcount + {4'd0, rx_wr} - {4'd0, pop};
                if (cap && !rx_wr) rxovf <= 1'b1;
                if (cap && bus.rxdpt != exp_idx) rxerr <= 1'b1;
            end
        end
    end
    assign bus.txdata  = txmem[bus.txdpt[AW-1:0]];
    assign bus.rxrdata = rxcount != 5'd0 ? rxmem[rp] : 32'd0;
    assign bus.txcount = txcount;
    assign bus.rxcount = rxcount;
    assign bus.txovf   = txovf;
    assign bus.rxovf   = rxovf;
    assign bus.rxerr   = rxerr;
    assign bus.busy    = state != IDLE;
    assign bus.done    = state == FIN;
    assign bus.txstart = state == START;
endmodule

// File: tb/tb_sc_spi_dbuf.sv
// tb_sc_spi_dbuf: directed and randomized checks of sc_spi_dbuf against a queue-based model.
module tb_sc_spi_dbuf;
    localparam int DEPTH = 16;
    localparam int NSYNC = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    logic [31:0] txm [DEPTH];
    int tcnt = 0;
    bit tovf = 0;
    logic [31:0] rxq [$];
    bit rovf = 0;
    bit rerr = 0;
    int exp_idx = 0;
    sc_spi_dbuf_if bus();
    sc_spi_dbuf #(.DEPTH(DEPTH), .NSYNC(NSYNC)) dut (.sysclk(clk), .sysrst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_status(string tag);
        chk({tag, ".txcount"}, 32'(bus.txcount), 32'(tcnt));
        chk({tag, ".rxcount"}, 32'(bus.rxcount), 32'(rxq.size()));
        chk({tag, ".txovf"}, 32'(bus.txovf), 32'(tovf));
        chk({tag, ".rxovf"}, 32'(bus.rxovf), 32'(rovf));
        chk({tag, ".rxerr"}, 32'(bus.rxerr), 32'(rerr));
    endtask

    task automatic push(logic [31:0] d, bit idle);
        bus.txwdata = d;
        bus.txwe = 1'b1;
        tick();
        bus.txwe = 1'b0;
        if (idle && tcnt < DEPTH) begin
            txm[tcnt] = d;
            tcnt++;
        end else tovf = 1;
    endtask

    task automatic capture(logic [31:0] d, logic [3:0] dpt, bit do_pop);
        bit pop_ok;
        bus.rxdata = d;
        bus.rxdpt = dpt;
        bus.rxvalid = 1'b1;
        tick(NSYNC);
        if (do_pop) begin
            chk("cap_pop.rxrdata", bus.rxrdata, rxq.size() != 0 ? rxq[0] : 32'd0);
            bus.rxre = 1'b1;
        end
        tick();
        bus.rxre = 1'b0;
        pop_ok = do_pop && rxq.size() != 0;
        if (pop_ok) void'(rxq.pop_front());
        if (rxq.size() < DEPTH) rxq.push_back(d);
        else rovf = 1;
        if (dpt != 4'(exp_idx)) rerr = 1;
        exp_idx++;
        bus.rxvalid = 1'b0;
        tick(3);
    endtask

    task automatic pop_chk(string tag);
        chk(tag, bus.rxrdata, rxq.size() != 0 ? rxq[0] : 32'd0);
        bus.rxre = 1'b1;
        tick();
        bus.rxre = 1'b0;
        if (rxq.size() != 0) void'(rxq.pop_front());
    endtask

    task automatic rx_clear();
        bus.rxclr = 1'b1;
        tick();
        bus.rxclr = 1'b0;
        rxq.delete();
        rovf = 0;
        rerr = 0;
    endtask

    task automatic xfer(bit fall, bit push_mid);
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        exp_idx = 0;
        chk("xfer.txstart", 32'(bus.txstart), 32'd1);
        chk("xfer.busy", 32'(bus.busy), 32'd1);
        if (push_mid) push(32'hdead_beef, 0);
        else tick();
        chk("xfer.txstart_hold", 32'(bus.txstart), 32'd1);
        bus.spibusy = 1'b1;
        tick();
        chk("xfer.run_txstart", 32'(bus.txstart), 32'd0);
        chk("xfer.run_busy", 32'(bus.busy), 32'd1);
        tick(2);
        chk("xfer.run_done", 32'(bus.done), 32'd0);
        if (fall) bus.spibusy = 1'b0;
        else bus.spicomplete = 1'b1;
        tick();
        chk("xfer.done", 32'(bus.done), 32'd1);
        bus.spicomplete = 1'b0;
        bus.spibusy = 1'b0;
        tick();
        tcnt = 0;
        chk("xfer.done_off", 32'(bus.done), 32'd0);
        chk("xfer.idle", 32'(bus.busy), 32'd0);
        chk("xfer.txcount", 32'(bus.txcount), 32'd0);
    endtask

    initial begin
        logic [3:0] dpt;
        bus.txwe = 0; bus.txwdata = 0; bus.txclr = 0; bus.rxre = 0; bus.rxclr = 0; bus.go = 0;
        bus.spibusy = 0; bus.spicomplete = 0; bus.txdpt = 0; bus.rxdata = 0; bus.rxdpt = 0; bus.rxvalid = 0;
        tick(2);
        rst = 1'b0;
        tick();
        chk_status("reset");
        chk("reset.busy", 32'(bus.busy), 32'd0);
        chk("reset.done", 32'(bus.done), 32'd0);
        chk("reset.txstart", 32'(bus.txstart), 32'd0);
        chk("reset.rxrdata", bus.rxrdata, 32'd0);
        push(32'h1111_1111, 1);
        push(32'h2222_2222, 1);
        push(32'h3333_3333, 1);
        bus.txdpt = 4'd2;
        #1;
        chk("load.txdata2", bus.txdata, 32'h3333_3333);
        bus.txdpt = 4'd0;
        #1;
        chk("load.txdata0", bus.txdata, 32'h1111_1111);
        chk_status("load");
        xfer(0, 1);
        chk_status("xfer1");
        bus.txclr = 1'b1;
        bus.txwe = 1'b1;
        tick();
        bus.txclr = 1'b0;
        bus.txwe = 1'b0;
        tcnt = 0;
        tovf = 0;
        chk_status("txclr_wins");
        capture(32'hAAAA_0001, 4'd0, 0);
        capture(32'hBBBB_0002, 4'd1, 0);
        capture(32'hCCCC_0003, 4'd2, 0);
        chk_status("rx3");
        pop_chk("rx3.pop_a");
        pop_chk("rx3.pop_b");
        pop_chk("rx3.pop_c");
        chk_status("rx3_empty");
        for (int i = 0; i < DEPTH + 1; i++) push($urandom, 1);
        chk_status("tx_full");
        for (int i = 0; i < 4; i++) begin
            bus.txdpt = 4'($urandom_range(15));
            #1;
            chk("tx_full.txdata", bus.txdata, txm[int'(bus.txdpt) % DEPTH]);
        end
        for (int i = 0; i < DEPTH + 1; i++) capture($urandom, 4'(exp_idx), 0);
        chk_status("rx_full");
        for (int i = 0; i < DEPTH; i++) pop_chk("rx_full.pop");
        chk_status("rx_drained");
        rx_clear();
        for (int i = 0; i < DEPTH; i++) capture($urandom, 4'(exp_idx), 0);
        capture($urandom, 4'(exp_idx), 1);
        chk_status("full_cap_pop");
        pop_chk("full_cap_pop.head");
        rx_clear();
        pop_chk("empty_pop");
        chk_status("empty_pop");
        bus.txclr = 1'b1;
        tick();
        bus.txclr = 1'b0;
        tcnt = 0;
        tovf = 0;
        push($urandom, 1);
        xfer(1, 0);
        dpt = 4'd5;
        capture($urandom, dpt, 0);
        chk_status("rxerr");
        rx_clear();
        chk_status("rxerr_clr");
        capture($urandom, 4'(exp_idx), 0);
        push($urandom, 1);
        push($urandom, 1);
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        bus.spibusy = 1'b1;
        tick();
        chk("pre_rst.busy", 32'(bus.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        tcnt = 0; tovf = 0; rxq.delete(); rovf = 0; rerr = 0; exp_idx = 0;
        chk_status("mid_rst");
        chk("mid_rst.busy", 32'(bus.busy), 32'd0);
        chk("mid_rst.txstart", 32'(bus.txstart), 32'd0);
        chk("mid_rst.done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        bus.spibusy = 1'b0;
        tick();
        bus.go = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("go_empty.txstart", 32'(bus.txstart), 32'd0);
            chk("go_empty.busy", 32'(bus.busy), 32'd0);
        end
        bus.go = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
